// File: rtl/ft245_stream_bridge.sv
// rtl/ft245_stream_bridge.sv - valid/ready byte streams to ft245_ifc toggle seq/ack bridge
//
// Purpose: buffers host TX bytes and ft245_ifc RX bytes in two independent FIFOs.
// It converts between valid/ready streams and ft245_ifc's toggle handshakes.
// Ports:
//   clk_i, reset_i                       clock, asynchronous active-high reset
//   tx_in_data_i/valid_i/ready_o         host -> bridge byte stream
//   rx_out_data_o/valid_o/ready_i        bridge -> host byte stream (show-ahead)
//   tx_level_o, rx_level_o               FIFO occupancies
//   ifc_tx_data_o/seq_o, ifc_tx_ack_i    toggle handshake toward ft245_ifc TX
//   ifc_rx_data_i/seq_i, ifc_rx_ack_o    toggle handshake from ft245_ifc RX
module ft245_stream_bridge #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [7:0]               tx_in_data_i,
  input  logic                     tx_in_valid_i,
  output logic                     tx_in_ready_o,
  output logic [7:0]               rx_out_data_o,
  output logic                     rx_out_valid_o,
  input  logic                     rx_out_ready_i,
  output logic [TX_DEPTH_LOG2:0]   tx_level_o,
  output logic [RX_DEPTH_LOG2:0]   rx_level_o,
  output logic [7:0]               ifc_tx_data_o,
  output logic                     ifc_tx_seq_o,
  input  logic                     ifc_tx_ack_i,
  input  logic [7:0]               ifc_rx_data_i,
  input  logic                     ifc_rx_seq_i,
  output logic                     ifc_rx_ack_o
);

  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

  typedef enum logic {ST_SYNC, ST_RUN} state_e;

  state_e                 state_q;
  logic [7:0]             ifc_tx_data_q;
  logic                   ifc_tx_seq_q;
  logic                   ifc_rx_ack_q;

  logic [7:0]             tx_mem_q [TX_DEPTH];
  logic [TX_DEPTH_LOG2:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [7:0]             rx_mem_q [RX_DEPTH];
  logic [RX_DEPTH_LOG2:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

  logic run;
  logic tx_empty, tx_full, tx_push, tx_pop;
  logic rx_empty, rx_full, rx_push, rx_pop;
  logic [7:0] tx_head;

  assign run = (state_q == ST_RUN);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TX_DEPTH_LOG2] != tx_rd_q[TX_DEPTH_LOG2]) &&
                    (tx_wr_q[TX_DEPTH_LOG2-1:0] == tx_rd_q[TX_DEPTH_LOG2-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RX_DEPTH_LOG2] != rx_rd_q[RX_DEPTH_LOG2]) &&
                    (rx_wr_q[RX_DEPTH_LOG2-1:0] == rx_rd_q[RX_DEPTH_LOG2-1:0]);

  assign tx_in_ready_o = run && !tx_full;
  assign tx_push       = tx_in_valid_i && tx_in_ready_o;
  // The ifc is free for a new byte once it has acked the last toggle.
  assign tx_pop        = run && (ifc_tx_seq_q == ifc_tx_ack_i) && !tx_empty;
  assign tx_head       = tx_mem_q[tx_rd_q[TX_DEPTH_LOG2-1:0]];

  // Withholding the ack while full stalls ft245_ifc, so no RX byte is dropped.
  assign rx_push       = run && (ifc_rx_seq_i != ifc_rx_ack_q) && !rx_full;
  assign rx_out_valid_o = !rx_empty;
  assign rx_pop        = rx_out_valid_o && rx_out_ready_i;
  assign rx_out_data_o = rx_mem_q[rx_rd_q[RX_DEPTH_LOG2-1:0]];

  assign tx_level_o    = tx_wr_q - tx_rd_q;
  assign rx_level_o    = rx_wr_q - rx_rd_q;

  assign ifc_tx_data_o = ifc_tx_data_q;
  assign ifc_tx_seq_o  = ifc_tx_seq_q;
  assign ifc_rx_ack_o  = ifc_rx_ack_q;

  always_comb begin
    tx_wr_d = tx_wr_q + {{TX_DEPTH_LOG2{1'b0}}, tx_push};
    tx_rd_d = tx_rd_q + {{TX_DEPTH_LOG2{1'b0}}, tx_pop};
    rx_wr_d = rx_wr_q + {{RX_DEPTH_LOG2{1'b0}}, rx_push};
    rx_rd_d = rx_rd_q + {{RX_DEPTH_LOG2{1'b0}}, rx_pop};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q[TX_DEPTH_LOG2-1:0]] <= tx_in_data_i;
    if (rx_push) rx_mem_q[rx_wr_q[RX_DEPTH_LOG2-1:0]] <= ifc_rx_data_i;
  end

  // ft245_ifc's seq/ack flops are not reset, so the first cycle after reset
  // adopts its current handshake levels instead of assuming zero.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_SYNC;
      ifc_tx_data_q <= 8'h00;
      ifc_tx_seq_q  <= 1'b0;
      ifc_rx_ack_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          ifc_tx_seq_q <= ifc_tx_ack_i;
          ifc_rx_ack_q <= ifc_rx_seq_i;
          state_q      <= ST_RUN;
        end
        default: begin
          if (tx_pop) begin
            ifc_tx_data_q <= tx_head;
            ifc_tx_seq_q  <= !ifc_tx_seq_q;
          end
          if (rx_push) ifc_rx_ack_q <= ifc_rx_seq_i;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_stream_bridge.sv
// tb/tb_ft245_stream_bridge.sv - self-checking bench for ft245_stream_bridge
module tb_ft245_stream_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_in_data = 8'h00;
  logic       tx_in_valid = 1'b0;
  logic       tx_in_ready;
  logic [7:0] rx_out_data;
  logic       rx_out_valid;
  logic       rx_out_ready = 1'b0;
  logic [4:0] tx_level;
  logic [4:0] rx_level;
  logic [7:0] ifc_tx_data;
  logic       ifc_tx_seq;
  logic       ifc_tx_ack = 1'b1;
  logic [7:0] ifc_rx_data = 8'h00;
  logic       ifc_rx_seq = 1'b1;
  logic       ifc_rx_ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  ft245_stream_bridge #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk_i(clk), .reset_i(rst),
    .tx_in_data_i(tx_in_data), .tx_in_valid_i(tx_in_valid), .tx_in_ready_o(tx_in_ready),
    .rx_out_data_o(rx_out_data), .rx_out_valid_o(rx_out_valid), .rx_out_ready_i(rx_out_ready),
    .tx_level_o(tx_level), .rx_level_o(rx_level),
    .ifc_tx_data_o(ifc_tx_data), .ifc_tx_seq_o(ifc_tx_seq), .ifc_tx_ack_i(ifc_tx_ack),
    .ifc_rx_data_i(ifc_rx_data), .ifc_rx_seq_i(ifc_rx_seq), .ifc_rx_ack_o(ifc_rx_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  // Called at a negedge; holds valid until the byte is taken on a rising edge.
  task automatic push_byte(input logic [7:0] b);
    int cnt = 0;
    tx_in_data  = b;
    tx_in_valid = 1'b1;
    while (!tx_in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!tx_in_ready) fail_now("push_timeout");
    else tx_q.push_back(b);
    @(negedge clk);
    tx_in_valid = 1'b0;
  endtask

  // ft245_ifc TX stub: wait for a toggle, check the byte, then ack it.
  task automatic tx_take(input string tag);
    int cnt = 0;
    while (ifc_tx_seq === ifc_tx_ack && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (ifc_tx_seq === ifc_tx_ack) fail_now({tag, "_timeout"});
    else if (tx_q.size() == 0) fail_now({tag, "_phantom"});
    else begin
      chk(tag, 32'(ifc_tx_data), 32'(tx_q.pop_front()));
      ifc_tx_ack = ifc_tx_seq;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int got;
    int cnt;

    // 1. reset values, then SYNC adopts stub handshake levels
    repeat (2) @(negedge clk);
    chk("rst_tx_level", 32'(tx_level), 0);
    chk("rst_rx_level", 32'(rx_level), 0);
    chk("rst_tx_ready", 32'(tx_in_ready), 0);
    chk("rst_rx_valid", 32'(rx_out_valid), 0);
    chk("rst_tx_seq", 32'(ifc_tx_seq), 0);
    chk("rst_rx_ack", 32'(ifc_rx_ack), 0);
    chk("rst_tx_data", 32'(ifc_tx_data), 0);
    rst = 1'b0;
    #1;
    chk("sync_tx_ready", 32'(tx_in_ready), 0);
    @(negedge clk);
    chk("sync_rx_ack", 32'(ifc_rx_ack), 1);
    chk("sync_tx_seq", 32'(ifc_tx_seq), 1);
    chk("run_tx_ready", 32'(tx_in_ready), 1);
    repeat (3) @(negedge clk);
    chk("sync_no_rx_push", 32'(rx_level), 0);
    chk("sync_no_tx_toggle", 32'(ifc_tx_seq), 1);

    // 2. single byte latency and no second toggle before ack
    tx_in_data  = 8'hA5;
    tx_in_valid = 1'b1;
    chk("t2_ready", 32'(tx_in_ready), 1);
    tx_q.push_back(8'hA5);
    @(negedge clk);
    tx_in_valid = 1'b0;
    chk("t2_level_after_e", 32'(tx_level), 1);
    chk("t2_seq_after_e", 32'(ifc_tx_seq), 1);
    @(negedge clk);
    chk("t2_seq_after_e1", 32'(ifc_tx_seq), 0);
    chk("t2_data_after_e1", 32'(ifc_tx_data), 'hA5);
    chk("t2_level_after_e1", 32'(tx_level), 0);
    push_byte(8'h5A);
    repeat (3) @(negedge clk);
    chk("t2_no_second_toggle", 32'(ifc_tx_seq), 0);
    chk("t2_data_held", 32'(ifc_tx_data), 'hA5);
    chk("t2_level_held", 32'(tx_level), 1);
    tx_take("t2_first");
    tx_take("t2_second");

    // 3. fill TX with ack held, check full boundary, then drain in order
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    chk("t3_level_full", 32'(tx_level), 16);
    chk("t3_ready_full", 32'(tx_in_ready), 0);
    chk("t3_ifc_first", 32'(ifc_tx_data), 0);
    tx_in_data  = 8'hEE;
    tx_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    tx_in_valid = 1'b0;
    chk("t3_full_rejects", 32'(tx_level), 16);
    for (int i = 0; i <= 16; i++) tx_take("t3_drain");
    repeat (2) @(negedge clk);
    chk("t3_drained_level", 32'(tx_level), 0);
    chk("t3_no_extra_toggle", 32'(ifc_tx_seq), 32'(ifc_tx_ack));

    // 4. single RX byte via seq toggle
    rx_out_ready = 1'b1;
    ifc_rx_data  = 8'h3C;
    ifc_rx_seq   = ~ifc_rx_seq;
    rx_q.push_back(8'h3C);
    @(negedge clk);
    chk("t4_rx_ack", 32'(ifc_rx_ack), 32'(ifc_rx_seq));
    chk("t4_rx_valid", 32'(rx_out_valid), 1);
    chk("t4_rx_data", 32'(rx_out_data), 32'(rx_q.pop_front()));
    @(negedge clk);
    chk("t4_rx_popped", 32'(rx_out_valid), 0);

    // 5. RX backpressure: 20 bytes offered while host stalls
    rx_out_ready = 1'b0;
    fork
      begin : rx_stub
        for (int i = 0; i < 20; i++) begin
          int w;
          ifc_rx_data = 8'(128 + i);
          ifc_rx_seq  = ~ifc_rx_seq;
          rx_q.push_back(8'(128 + i));
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (ifc_rx_ack !== ifc_rx_seq && w < 400);
          if (ifc_rx_ack !== ifc_rx_seq) begin
            fail_now("t5_stub_ack_timeout");
            break;
          end
        end
      end
      begin : rx_host
        cnt = 0;
        while (rx_level !== 5'd16 && cnt < 200) begin
          @(negedge clk);
          cnt++;
        end
        repeat (4) @(negedge clk);
        chk("t5_rx_level_full", 32'(rx_level), 16);
        chk("t5_ack_withheld", 32'(ifc_rx_ack != ifc_rx_seq), 1);
        rx_out_ready = 1'b1;
        got = 0;
        cnt = 0;
        while (got < 20 && cnt < 400) begin
          if (rx_out_valid) begin
            if (rx_q.size() == 0) fail_now("t5_phantom");
            else chk("t5_rx_data", 32'(rx_out_data), 32'(rx_q.pop_front()));
            got++;
          end
          @(negedge clk);
          cnt++;
        end
        if (got < 20) fail_now("t5_rx_timeout");
      end
    join
    repeat (3) @(negedge clk);
    chk("t5_rx_empty", 32'(rx_level), 0);
    chk("t5_ack_match", 32'(ifc_rx_ack), 32'(ifc_rx_seq));

    // 6. reset with 5 bytes in TX, one at the ifc, and an RX toggle pending
    rx_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h40 + 8'(i)));
    chk("t6_tx_level", 32'(tx_level), 5);
    ifc_rx_data = 8'h77;
    ifc_rx_seq  = ~ifc_rx_seq;
    rst = 1'b1;
    #1;
    chk("t6_rst_tx_level", 32'(tx_level), 0);
    chk("t6_rst_rx_level", 32'(rx_level), 0);
    chk("t6_rst_tx_seq", 32'(ifc_tx_seq), 0);
    chk("t6_rst_rx_ack", 32'(ifc_rx_ack), 0);
    chk("t6_rst_tx_data", 32'(ifc_tx_data), 0);
    chk("t6_rst_tx_ready", 32'(tx_in_ready), 0);
    tx_q.delete();
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_sync_rx_ack", 32'(ifc_rx_ack), 32'(ifc_rx_seq));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_tx_emit", 32'(ifc_tx_seq), 32'(ifc_tx_ack));
      chk("t6_no_rx_push", 32'(rx_level), 0);
    end
    chk("t6_rx_valid", 32'(rx_out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
